mpeg_input_stream_bitreader: RTL and testbench

Read side of the 32 KB MPEG input stream FIFO: fetches complete 32-bit words from the mixed-width stream RAM (8-bit write port, 8192×32 read port, 1-cycle registered read) and presents them to the FMV decoder as an MSB-first bitstream with peek/consume semantics. It owns the read word pointer and exports it back so the byte writer can compute free space. Sits between the stream RAM and the video/audio syntax parsers.

---
 rtl/mpeg_fifo_pkg.sv | 20 ++
 rtl/mpeg_input_stream_bitreader_if.sv | 22 ++
 rtl/mpeg_input_stream_bitreader.sv | 82 ++++++++
 tb/tb_mpeg_input_stream_bitreader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mpeg_fifo_pkg.sv
// Shared types and helpers for the 32 KB MPEG input stream FIFO.
// Pointers carry one wrap bit above the address bits so full and empty differ.
package mpeg_fifo_pkg;

  localparam int FIFO_WORDS = 8192;
  localparam int FIFO_BYTES = 32768;

  typedef logic [$clog2(FIFO_BYTES):0] byte_ptr_t;
  typedef logic [$clog2(FIFO_WORDS):0] word_ptr_t;
  typedef logic [6:0]                  level_t;
  typedef logic [5:0]                  len_t;

  localparam level_t WORD_BITS = 7'd32;

  // RAM words are little-endian by byte address; the stream wants address 0 first.
  function automatic logic [31:0] stream_order(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mpeg_input_stream_bitreader_if.sv
// Peek/consume bitstream port between the stream bit reader and the syntax parsers.
// master = bit reader, slave = parser.
interface mpeg_input_stream_bitreader_if;
  import mpeg_fifo_pkg::*;

  logic [31:0] show_bits;
  level_t      level;
  logic        show_valid;
  logic        consume;
  len_t        consume_len;

  modport master (
    output show_bits, level, show_valid,
    input  consume, consume_len
  );

  modport slave (
    input  show_bits, level, show_valid,
    output consume, consume_len
  );

endinterface

// File: rtl/mpeg_input_stream_bitreader.sv
// Read side of the MPEG stream FIFO: fetches whole words from the stream RAM into a
// 64-bit left-aligned buffer and serves them MSB-first with peek/consume semantics.
module mpeg_input_stream_bitreader
  import mpeg_fifo_pkg::*;
#(
  parameter int WORD_AW = 13
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  byte_ptr_t             wr_byte_ptr,
  output byte_ptr_t             rd_byte_ptr,
  output logic [WORD_AW-1:0]    raddr,
  input  logic [31:0]           q,
  mpeg_input_stream_bitreader_if.master strm
);

  logic [63:0] r_buf;
  level_t      r_level;
  word_ptr_t   r_rd_word_ptr;
  logic        r_inflight;
  logic        r_show_valid;

  byte_ptr_t   w_rd_byte_ptr;
  byte_ptr_t   w_byte_gap;
  logic        w_words_avail;
  logic        w_fetch;
  len_t        w_shift;
  level_t      w_level_cons;
  level_t      w_level_next;
  logic [63:0] w_buf_next;

  assign w_rd_byte_ptr = {r_rd_word_ptr, 2'b00};

  always_comb begin
    // Read pointer is word aligned, so a gap of 4+ bytes means a complete word exists.
    w_byte_gap    = wr_byte_ptr - w_rd_byte_ptr;
    w_words_avail = (w_byte_gap >= byte_ptr_t'(4));
    w_fetch       = !r_inflight && (r_level <= WORD_BITS) && w_words_avail && !clear;

    w_shift       = strm.consume ? strm.consume_len : '0;
    w_level_cons  = r_level - level_t'(w_shift);
    w_buf_next    = r_buf << w_shift;
    w_level_next  = w_level_cons;
    // The shift comes first; the returning word lands directly below the remaining bits.
    if (r_inflight) begin
      w_buf_next   = w_buf_next | ({stream_order(q), 32'h0} >> w_level_cons);
      w_level_next = w_level_cons + WORD_BITS;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf         <= '0;
      r_level       <= '0;
      r_rd_word_ptr <= '0;
      r_inflight    <= 1'b0;
      r_show_valid  <= 1'b0;
    end else if (clear) begin
      r_buf         <= '0;
      r_level       <= '0;
      r_rd_word_ptr <= '0;
      r_inflight    <= 1'b0;
      r_show_valid  <= 1'b0;
    end else begin
      r_buf         <= w_buf_next;
      r_level       <= w_level_next;
      r_show_valid  <= (w_level_next >= WORD_BITS);
      r_inflight    <= w_fetch;
      if (w_fetch) begin
        r_rd_word_ptr <= r_rd_word_ptr + word_ptr_t'(1);
      end
    end
  end

  assign raddr           = r_rd_word_ptr[WORD_AW-1:0];
  assign rd_byte_ptr     = w_rd_byte_ptr;
  assign strm.show_bits  = r_buf[63:32];
  assign strm.level      = r_level;
  assign strm.show_valid = r_show_valid;

endmodule

// File: tb/tb_mpeg_input_stream_bitreader.sv
// Self-checking bench for mpeg_input_stream_bitreader: byte-addressed RAM model,
// vector table for bit-level consumes, scoreboard for streamed words.
module tb_mpeg_input_stream_bitreader;
  import mpeg_fifo_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  byte_ptr_t   wr_byte_ptr = '0;
  byte_ptr_t   rd_byte_ptr;
  logic [12:0] raddr;
  logic [31:0] q = '0;

  mpeg_input_stream_bitreader_if sif();

  mpeg_input_stream_bitreader #(.WORD_AW(13)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .wr_byte_ptr(wr_byte_ptr),
    .rd_byte_ptr(rd_byte_ptr),
    .raddr      (raddr),
    .q          (q),
    .strm       (sif)
  );

  always #5 clk = ~clk;

  // Stream RAM model: byte write port, 32-bit registered read, little-endian by address.
  logic [7:0] mem [FIFO_BYTES];
  always @(posedge clk)
    q <= {mem[{raddr, 2'd3}], mem[{raddr, 2'd2}], mem[{raddr, 2'd1}], mem[{raddr, 2'd0}]};

  always @(posedge clk)
    if (reset_n && sif.consume)
      assert (sif.consume_len <= sif.level && sif.consume_len <= 6'd32)
        else $error("consume_len %0d exceeds level %0d", sif.consume_len, sif.level);

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [5:0]  len;
    logic [31:0] exp_bits;
    logic [6:0]  exp_level;
    logic        exp_valid;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    mem[wr_byte_ptr[14:0]] = b;
    wr_byte_ptr = wr_byte_ptr + byte_ptr_t'(1);
  endtask

  // w is in stream order (first byte in w[31:24]).
  task automatic put_word(input logic [31:0] w, input bit push);
    put_byte(w[31:24]);
    put_byte(w[23:16]);
    put_byte(w[15:8]);
    put_byte(w[7:0]);
    if (push) sb_q.push_back(w);
  endtask

  task automatic consume_n(input logic [5:0] len);
    sif.consume     = 1'b1;
    sif.consume_len = len;
    tick();
    sif.consume     = 1'b0;
    sif.consume_len = '0;
  endtask

  // Pops each expected word when the DUT shows a full word, then consumes it.
  task automatic stream_words(input string name);
    int  n;
    bit  ok;
    logic [31:0] exp;
    ok = 1'b1;
    while (ok && sb_q.size() > 0) begin
      n = 0;
      while (!sif.show_valid && n < 20) begin
        tick();
        n++;
      end
      if (!sif.show_valid) begin
        chk({name, "_timeout"}, 64'(sif.show_valid), 64'd1);
        ok = 1'b0;
      end else begin
        exp = sb_q.pop_front();
        chk(name, 64'(sif.show_bits), 64'(exp));
        if (sif.show_bits !== exp) ok = 1'b0;
        consume_n(6'd32);
      end
    end
    sb_q.delete();
  endtask

  initial begin
    vecs[0] = '{6'd0,  32'h12345678, 7'd64, 1'b1};
    vecs[1] = '{6'd4,  32'h23456789, 7'd60, 1'b1};
    vecs[2] = '{6'd28, 32'h9ABCDEF0, 7'd32, 1'b1};
    vecs[3] = '{6'd8,  32'hBCDEF000, 7'd24, 1'b0};
    vecs[4] = '{6'd0,  32'hBCDEF000, 7'd24, 1'b0};
    vecs[5] = '{6'd24, 32'h00000000, 7'd0,  1'b0};

    for (int i = 0; i < FIFO_BYTES; i++) mem[i] = 8'h00;
    sif.consume     = 1'b0;
    sif.consume_len = '0;

    // Reset state
    tick();
    tick();
    chk("rst_show_bits", 64'(sif.show_bits), 64'd0);
    chk("rst_level", 64'(sif.level), 64'd0);
    chk("rst_show_valid", 64'(sif.show_valid), 64'd0);
    chk("rst_raddr", 64'(raddr), 64'd0);
    chk("rst_rd_byte_ptr", 64'(rd_byte_ptr), 64'd0);
    reset_n = 1'b1;
    tick();

    // Partial word is never fetched; the fourth byte triggers fetch then append
    put_byte(8'h12); put_byte(8'h34); put_byte(8'h56);
    tick(); tick(); tick();
    chk("partial_level", 64'(sif.level), 64'd0);
    chk("partial_raddr", 64'(raddr), 64'd0);
    put_byte(8'h78);
    tick();
    chk("lat_e1_raddr", 64'(raddr), 64'd1);
    chk("lat_e1_level", 64'(sif.level), 64'd0);
    tick();
    chk("lat_e2_bits", 64'(sif.show_bits), 64'h12345678);
    chk("lat_e2_level", 64'(sif.level), 64'd32);
    chk("lat_e2_valid", 64'(sif.show_valid), 64'd1);
    $display("latency: word 0x%08h shown, level %0d", sif.show_bits, sif.level);

    put_byte(8'h9A); put_byte(8'hBC); put_byte(8'hDE); put_byte(8'hF0);
    tick(); tick();

    // Bit-level consume table on the 64-bit buffer
    for (int i = 0; i < 6; i++) begin
      consume_n(vecs[i].len);
      chk($sformatf("vec%0d_bits", i), 64'(sif.show_bits), 64'(vecs[i].exp_bits));
      chk($sformatf("vec%0d_level", i), 64'(sif.level), 64'(vecs[i].exp_level));
      chk($sformatf("vec%0d_valid", i), 64'(sif.show_valid), 64'(vecs[i].exp_valid));
      $display("vector %0d: consume %0d -> bits 0x%08h level %0d", i, vecs[i].len,
               sif.show_bits, sif.level);
    end

    // Consume 32 in the same cycle the in-flight word is appended
    put_word(32'h11223344, 1'b0);
    tick(); tick();
    chk("app_pre_bits", 64'(sif.show_bits), 64'h11223344);
    put_word(32'h55667788, 1'b0);
    tick();
    chk("app_fetch_raddr", 64'(raddr), 64'd4);
    consume_n(6'd32);
    chk("app_bits", 64'(sif.show_bits), 64'h55667788);
    chk("app_level", 64'(sif.level), 64'd32);
    $display("append+consume: bits 0x%08h level %0d", sif.show_bits, sif.level);
    consume_n(6'd32);
    chk("app_drain_level", 64'(sif.level), 64'd0);

    // Clear in the cycle the read data returns; writer restarts at 0
    put_word(32'hDEADBEEF, 1'b0);
    tick();
    clear       = 1'b1;
    wr_byte_ptr = '0;
    tick();
    clear = 1'b0;
    chk("clr_level", 64'(sif.level), 64'd0);
    chk("clr_bits", 64'(sif.show_bits), 64'd0);
    chk("clr_raddr", 64'(raddr), 64'd0);
    chk("clr_rd_byte_ptr", 64'(rd_byte_ptr), 64'd0);
    tick();
    chk("clr_idle_level", 64'(sif.level), 64'd0);
    put_word(32'hA1B2C3D4, 1'b0);
    chk("clr_restart_raddr", 64'(raddr), 64'd0);
    tick(); tick();
    chk("clr_restart_bits", 64'(sif.show_bits), 64'hA1B2C3D4);
    chk("clr_restart_level", 64'(sif.level), 64'd32);
    $display("clear: restart word 0x%08h", sif.show_bits);
    consume_n(6'd32);

    // Stream up to the last RAM word, then across the wrap
    for (int i = 0; i < 8190; i++) put_word($urandom, 1'b1);
    stream_words("stream");
    chk("pre_wrap_raddr", 64'(raddr), 64'd8191);
    chk("pre_wrap_rd_byte_ptr", 64'(rd_byte_ptr), 64'h7FFC);
    chk("pre_wrap_level", 64'(sif.level), 64'd0);
    $display("stream: 8190 words, rd_byte_ptr 0x%04h", rd_byte_ptr);
    put_word(32'hCAFEF00D, 1'b1);
    put_word(32'h0BADC0DE, 1'b1);
    tick();
    chk("wrap_second_raddr", 64'(raddr), 64'd0);
    stream_words("wrap");
    chk("wrap_rd_byte_ptr", 64'(rd_byte_ptr), 64'h8004);
    tick(); tick(); tick();
    chk("wrap_empty_level", 64'(sif.level), 64'd0);
    chk("wrap_empty_raddr", 64'(raddr), 64'd1);
    $display("wrap: rd_byte_ptr 0x%04h level %0d", rd_byte_ptr, sif.level);

    // Asynchronous reset with level = 40
    put_word(32'h01020304, 1'b0);
    put_word(32'h05060708, 1'b0);
    for (int n = 0; n < 10 && sif.level != 7'd64; n++) tick();
    consume_n(6'd24);
    chk("arst_pre_level", 64'(sif.level), 64'd40);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_level", 64'(sif.level), 64'd0);
    chk("arst_bits", 64'(sif.show_bits), 64'd0);
    chk("arst_valid", 64'(sif.show_valid), 64'd0);
    chk("arst_raddr", 64'(raddr), 64'd0);
    chk("arst_rd_byte_ptr", 64'(rd_byte_ptr), 64'd0);
    $display("async reset: level %0d raddr %0d", sif.level, raddr);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
